radix2_butterfly_cfg: RTL and testbench
=======================================

Name: radix2_butterfly_cfg

Overview:
Parametrised, fully pipelined radix-2 complex butterfly for the streaming FFT engine. It supersedes the fixed 16-bit DIF-only butterfly. It adds generic data and twiddle widths, per-transaction DIF/DIT selection, optional divide-by-2 stage scaling, round-half-up, output saturation and a sticky overflow flag. It sits between the stage memory read port and the write-back port, accepting one butterfly per cycle and carrying ctrl/address tags alongside the data.

Parameters:
DW, 16, data width; signed two's complement, all four data components.
TW, 16, twiddle width; signed Q1.(TW-1), range [-1.0, 1.0).
AW, 9, width of the memory address tag.
CW, 2, width of the control tag.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high
iact  in  1  input valid; one butterfly per asserted cycle
ictrl  in  CW  control tag, carried to octrl
iaddr  in  AW  address tag, carried to oaddr
imode  in  1  0 = DIF, 1 = DIT; sampled with iact
iscale  in  1  1 = divide outputs by 2; sampled with iact
a_re, a_im, b_re, b_im  in  DW each  input operands A and B
w_re, w_im  in  TW each  twiddle W, sampled in the same cycle as the data
oact  out  1  output valid
octrl  out  CW  delayed ictrl
oaddr  out  AW  delayed iaddr
oa_re, oa_im, ob_re, ob_im  out  DW each  results A', B'
ovf  out  1  sticky saturation flag
ovf_clr  in  1  clears ovf

Behaviour:
- Reset (synchronous): clk and reset as decided above.
  - oact=0, octrl=0, oaddr=0, all data outputs=0, ovf=0.
  - All internal stage valid bits are cleared, so in-flight transactions are discarded and never produce oact.
  - Reset dominates iact in the same cycle.
- Latency: exactly 4 cycles in both modes.
  - A transaction sampled with iact at edge N produces oact=1 after edge N+4.
  - Throughput is 1 per cycle with no stall input. Bubbles propagate as oact=0.
- Sideband: ctrl, addr, mode and scale travel in lock-step with their data.
  - Mixing DIF and DIT or scaled and unscaled transactions back-to-back is legal.
- Output hold: output data, octrl and oaddr update only on cycles where a valid transaction leaves stage 4. Otherwise they hold their last value.
- DIF (imode=0): A' = A+B; B' = (A-B)*W.
  - S1: sum and difference at DW+1 bits.
  - S2: four products, each full width (DW+1)+TW.
  - S3: re = rr - ii, im = ri + ir at full width +1; round by adding 2^(TW-2), then arithmetic shift right by TW-1. The sum path is delayed to match.
  - S4: scale and saturate.
- DIT (imode=1): T = B*W; A' = A+T; B' = A-T.
  - S1: register the inputs.
  - S2: B*W products.
  - S3: combine and round as in DIF, giving T at DW+2 bits. A is delayed to match.
  - S4: A±T at DW+3 bits, then scale and saturate.
- Scale: when iscale=1, each result component becomes (x+1)>>>1 (arithmetic), applied before saturation.
- Saturation: each component is clipped to [-2^(DW-1), 2^(DW-1)-1].
  - ovf is set on the edge where a valid output has any component clipped.
  - ovf_clr clears ovf. If a set and ovf_clr occur in the same cycle, the set wins and ovf=1.
- Twiddle edge case: W=-1.0 (0x8000 for TW=16) is legal and exact; no internal width overflows on it.
- Tag reuse: the ctrl/addr tag is not interpreted by this block.

Test Plan:
1. DIF exact: DW=TW=16, A=(1000,200), B=(300,-100), W=(0x8000,0), scale=0 -> 4 cycles later oact=1, A'=(1300,100), B'=(-700,-300), ovf=0.
2. DIT exact: same A and B, W=(0,0x8000) i.e. -j, imode=1 -> T=(-100,-300), A'=(900,-100), B'=(1100,500).
3. Saturation and scale: A=B=(32767,0), DIF.
   - scale=0 -> oa_re=32767, ovf=1.
   - After ovf_clr, the same inputs with scale=1 -> oa_re=32767, ob=(0,0), ovf stays 0.
4. Streaming: 8 consecutive iact cycles with addr 0..7, alternating imode and ctrl 0..3 -> 8 consecutive oact cycles starting 4 cycles after the first input. Tags and results match a reference model in order, with no bubbles.
5. Reset mid-flight: issue 3 transactions, then assert reset for 1 cycle at the 2nd edge after the first iact -> oact never asserts for them, outputs=0, ovf=0. The next transaction after reset completes normally with 4-cycle latency.
6. ovf priority: a saturating output lands on the same edge as ovf_clr=1 -> ovf=1 afterwards; ovf_clr alone on the next cycle -> ovf=0.

Source files
------------

// File: rtl/radix2_butterfly_cfg.sv
// Parametrised, fully pipelined radix-2 complex butterfly.
//   DIF (imode=0): A' = A + B,  B' = (A - B) * W
//   DIT (imode=1): T = B * W,   A' = A + T, B' = A - T
// Optional divide-by-2 scaling, round-half-up twiddle products, output saturation and
// a sticky overflow flag. Accepts one butterfly per cycle. A transaction sampled at
// edge N appears on the outputs after edge N+4.
//
// Ports:
//   clk, reset            clock (rising edge), synchronous active-high reset
//   iact                  input valid
//   ictrl/iaddr           sideband tags, carried unmodified to octrl/oaddr
//   imode                 0 = DIF, 1 = DIT (per transaction)
//   iscale                1 = divide results by 2 (per transaction)
//   a_re/a_im/b_re/b_im   signed operands A and B (DW bits)
//   w_re/w_im             signed twiddle, Q1.(TW-1)
//   oact                  output valid
//   octrl/oaddr           delayed tags
//   oa_re/oa_im/ob_re/ob_im  results A' and B'; held while oact=0
//   ovf                   sticky saturation flag
//   ovf_clr               clears ovf (a simultaneous set wins)
module radix2_butterfly_cfg #(
  parameter int unsigned DW = 16,
  parameter int unsigned TW = 16,
  parameter int unsigned AW = 9,
  parameter int unsigned CW = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          iact,
  input  logic [CW-1:0] ictrl,
  input  logic [AW-1:0] iaddr,
  input  logic          imode,
  input  logic          iscale,
  input  logic [DW-1:0] a_re,
  input  logic [DW-1:0] a_im,
  input  logic [DW-1:0] b_re,
  input  logic [DW-1:0] b_im,
  input  logic [TW-1:0] w_re,
  input  logic [TW-1:0] w_im,
  output logic          oact,
  output logic [CW-1:0] octrl,
  output logic [AW-1:0] oaddr,
  output logic [DW-1:0] oa_re,
  output logic [DW-1:0] oa_im,
  output logic [DW-1:0] ob_re,
  output logic [DW-1:0] ob_im,
  output logic          ovf,
  input  logic          ovf_clr
);

  localparam int unsigned SumW  = DW + 1;          // A+B / A-B
  localparam int unsigned ProdW = SumW + TW;       // full-width partial product
  localparam int unsigned CmbW  = ProdW + 1;       // rr-ii / ri+ir
  localparam int unsigned RndW  = CmbW - (TW - 1); // rounded product
  localparam int unsigned OutW  = DW + 4;          // A +/- T before scale/saturate

  localparam logic signed [CmbW-1:0] RndK   = CmbW'(1) << (TW - 2);
  localparam logic signed [OutW-1:0] SatMax = {{(OutW-DW+1){1'b0}}, {(DW-1){1'b1}}};
  localparam logic signed [OutW-1:0] SatMin = {{(OutW-DW+1){1'b1}}, {(DW-1){1'b0}}};

  typedef struct packed {
    logic          vld;
    logic          mode;
    logic          scale;
    logic [CW-1:0] ctrl;
    logic [AW-1:0] addr;
  } tag_t;

  typedef struct packed {
    tag_t                   tag;
    logic signed [DW-1:0]   a_re, a_im, b_re, b_im;
    logic signed [TW-1:0]   w_re, w_im;
  } s0_t;

  // p: pass-through operand (A+B for DIF, A for DIT); q: multiplicand (A-B or B)
  typedef struct packed {
    tag_t                   tag;
    logic signed [SumW-1:0] p_re, p_im, q_re, q_im;
    logic signed [TW-1:0]   w_re, w_im;
  } s1_t;

  typedef struct packed {
    tag_t                    tag;
    logic signed [SumW-1:0]  p_re, p_im;
    logic signed [ProdW-1:0] rr, ii, ri, ir;
  } s2_t;

  typedef struct packed {
    tag_t                   tag;
    logic signed [SumW-1:0] p_re, p_im;
    logic signed [RndW-1:0] t_re, t_im;
  } s3_t;

  typedef struct packed {
    logic          vld;
    logic [CW-1:0] ctrl;
    logic [AW-1:0] addr;
    logic [DW-1:0] a_re, a_im, b_re, b_im;
  } out_t;

  s0_t  s0_d, s0_q;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  s3_t  s3_d, s3_q;
  out_t out_d, out_q;
  logic ovf_d, ovf_q;

  // Returns {clipped, value}: optional (x+1)>>>1, then clip to DW bits.
  function automatic logic [DW:0] scale_sat(input logic signed [OutW-1:0] x,
                                            input logic                   scale);
    logic signed [OutW-1:0] y;
    y = scale ? ((x + OutW'(1)) >>> 1) : x;
    if (y > SatMax) begin
      scale_sat = {1'b1, DW'(SatMax)};
    end else if (y < SatMin) begin
      scale_sat = {1'b1, DW'(SatMin)};
    end else begin
      scale_sat = {1'b0, DW'(y)};
    end
  endfunction

  always_comb begin
    s0_d           = s0_q;
    s0_d.tag.vld   = iact;
    s0_d.tag.mode  = imode;
    s0_d.tag.scale = iscale;
    s0_d.tag.ctrl  = ictrl;
    s0_d.tag.addr  = iaddr;
    s0_d.a_re      = a_re;
    s0_d.a_im      = a_im;
    s0_d.b_re      = b_re;
    s0_d.b_im      = b_im;
    s0_d.w_re      = w_re;
    s0_d.w_im      = w_im;
  end

  always_comb begin
    s1_d      = s1_q;
    s1_d.tag  = s0_q.tag;
    s1_d.w_re = s0_q.w_re;
    s1_d.w_im = s0_q.w_im;
    if (s0_q.tag.mode) begin
      s1_d.p_re = SumW'(s0_q.a_re);
      s1_d.p_im = SumW'(s0_q.a_im);
      s1_d.q_re = SumW'(s0_q.b_re);
      s1_d.q_im = SumW'(s0_q.b_im);
    end else begin
      s1_d.p_re = SumW'(s0_q.a_re) + SumW'(s0_q.b_re);
      s1_d.p_im = SumW'(s0_q.a_im) + SumW'(s0_q.b_im);
      s1_d.q_re = SumW'(s0_q.a_re) - SumW'(s0_q.b_re);
      s1_d.q_im = SumW'(s0_q.a_im) - SumW'(s0_q.b_im);
    end
  end

  always_comb begin
    s2_d      = s2_q;
    s2_d.tag  = s1_q.tag;
    s2_d.p_re = s1_q.p_re;
    s2_d.p_im = s1_q.p_im;
    s2_d.rr   = ProdW'(s1_q.q_re) * ProdW'(s1_q.w_re);
    s2_d.ii   = ProdW'(s1_q.q_im) * ProdW'(s1_q.w_im);
    s2_d.ri   = ProdW'(s1_q.q_re) * ProdW'(s1_q.w_im);
    s2_d.ir   = ProdW'(s1_q.q_im) * ProdW'(s1_q.w_re);
  end

  // Round half up: add half an LSB of the Q1.(TW-1) result, then drop the fraction.
  always_comb begin
    s3_d      = s3_q;
    s3_d.tag  = s2_q.tag;
    s3_d.p_re = s2_q.p_re;
    s3_d.p_im = s2_q.p_im;
    s3_d.t_re = RndW'((CmbW'(s2_q.rr) - CmbW'(s2_q.ii) + RndK) >>> (TW - 1));
    s3_d.t_im = RndW'((CmbW'(s2_q.ri) + CmbW'(s2_q.ir) + RndK) >>> (TW - 1));
  end

  logic signed [OutW-1:0] xa_re, xa_im, xb_re, xb_im;
  logic        [DW:0]     sa_re, sa_im, sb_re, sb_im;
  logic                   clip_any;

  always_comb begin
    if (s3_q.tag.mode) begin
      xa_re = OutW'(s3_q.p_re) + OutW'(s3_q.t_re);
      xa_im = OutW'(s3_q.p_im) + OutW'(s3_q.t_im);
      xb_re = OutW'(s3_q.p_re) - OutW'(s3_q.t_re);
      xb_im = OutW'(s3_q.p_im) - OutW'(s3_q.t_im);
    end else begin
      xa_re = OutW'(s3_q.p_re);
      xa_im = OutW'(s3_q.p_im);
      xb_re = OutW'(s3_q.t_re);
      xb_im = OutW'(s3_q.t_im);
    end
    sa_re    = scale_sat(xa_re, s3_q.tag.scale);
    sa_im    = scale_sat(xa_im, s3_q.tag.scale);
    sb_re    = scale_sat(xb_re, s3_q.tag.scale);
    sb_im    = scale_sat(xb_im, s3_q.tag.scale);
    clip_any = sa_re[DW] | sa_im[DW] | sb_re[DW] | sb_im[DW];
  end

  // Outputs hold their last value unless a valid transaction leaves the pipe.
  always_comb begin
    out_d     = out_q;
    out_d.vld = s3_q.tag.vld;
    if (s3_q.tag.vld) begin
      out_d.ctrl = s3_q.tag.ctrl;
      out_d.addr = s3_q.tag.addr;
      out_d.a_re = sa_re[DW-1:0];
      out_d.a_im = sa_im[DW-1:0];
      out_d.b_re = sb_re[DW-1:0];
      out_d.b_im = sb_im[DW-1:0];
    end
  end

  // Set beats clear when both happen on the same edge.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (s3_q.tag.vld && clip_any) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s0_q  <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      out_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      s0_q  <= s0_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      out_q <= out_d;
      ovf_q <= ovf_d;
    end
  end

  assign oact  = out_q.vld;
  assign octrl = out_q.ctrl;
  assign oaddr = out_q.addr;
  assign oa_re = out_q.a_re;
  assign oa_im = out_q.a_im;
  assign ob_re = out_q.b_re;
  assign ob_im = out_q.b_im;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_radix2_butterfly_cfg.sv
// Scoreboard bench for radix2_butterfly_cfg (DW=TW=16, AW=9, CW=2).
// Stimulus pushes expected results (with their due cycle) into a queue; a monitor pops
// and compares on every oact.
module tb_radix2_butterfly_cfg;
  localparam int DW = 16;
  localparam int TW = 16;
  localparam int AW = 9;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          iact;
  logic [CW-1:0] ictrl;
  logic [AW-1:0] iaddr;
  logic          imode, iscale;
  logic [DW-1:0] a_re, a_im, b_re, b_im;
  logic [TW-1:0] w_re, w_im;
  logic          oact;
  logic [CW-1:0] octrl;
  logic [AW-1:0] oaddr;
  logic [DW-1:0] oa_re, oa_im, ob_re, ob_im;
  logic          ovf;
  logic          ovf_clr;

  radix2_butterfly_cfg #(.DW(DW), .TW(TW), .AW(AW), .CW(CW)) dut (
    .clk(clk), .reset(reset), .iact(iact), .ictrl(ictrl), .iaddr(iaddr),
    .imode(imode), .iscale(iscale), .a_re(a_re), .a_im(a_im), .b_re(b_re), .b_im(b_im),
    .w_re(w_re), .w_im(w_im), .oact(oact), .octrl(octrl), .oaddr(oaddr),
    .oa_re(oa_re), .oa_im(oa_im), .ob_re(ob_re), .ob_im(ob_im), .ovf(ovf),
    .ovf_clr(ovf_clr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [CW-1:0]        ctrl;
    logic [AW-1:0]        addr;
    logic signed [DW-1:0] ar, ai, br, bi;
    int                   cyc;
  } exp_t;

  exp_t sb[$];
  exp_t e;
  int   n_vec = 0;
  int   n_bad = 0;

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compare every presented output against the head of the scoreboard.
  always @(posedge clk) begin
    #1;
    if (oact !== 1'b0) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL unexpected_oact: oact=%b at cycle %0d, required 0", oact, cyc);
      end else begin
        e = sb.pop_front();
        if (oact !== 1'b1 || octrl !== e.ctrl || oaddr !== e.addr ||
            $signed(oa_re) !== e.ar || $signed(oa_im) !== e.ai ||
            $signed(ob_re) !== e.br || $signed(ob_im) !== e.bi || cyc != e.cyc) begin
          n_bad++;
          $display("FAIL txn_addr%0d: got ctrl=%0d addr=%0d A=(%0d,%0d) B=(%0d,%0d) cyc=%0d, required ctrl=%0d addr=%0d A=(%0d,%0d) B=(%0d,%0d) cyc=%0d",
                   e.addr, octrl, oaddr, $signed(oa_re), $signed(oa_im), $signed(ob_re),
                   $signed(ob_im), cyc, e.ctrl, e.addr, e.ar, e.ai, e.br, e.bi, e.cyc);
        end
      end
    end
  end

  task automatic drive(input int ctrl, input int addr, input bit mode, input bit scale,
                       input int ar, input int ai, input int br, input int bi,
                       input int wr, input int wi);
    @(negedge clk);
    iact   = 1'b1;
    ictrl  = CW'(ctrl);
    iaddr  = AW'(addr);
    imode  = mode;
    iscale = scale;
    a_re   = DW'(ar);
    a_im   = DW'(ai);
    b_re   = DW'(br);
    b_im   = DW'(bi);
    w_re   = TW'(wr);
    w_im   = TW'(wi);
  endtask

  // Called in the same time step as drive(): sampled at the next edge, due 4 edges later.
  task automatic push(input int ctrl, input int addr, input int ar, input int ai,
                      input int br, input int bi);
    exp_t x;
    x.ctrl = CW'(ctrl);
    x.addr = AW'(addr);
    x.ar   = DW'(ar);
    x.ai   = DW'(ai);
    x.br   = DW'(br);
    x.bi   = DW'(bi);
    x.cyc  = cyc + 5;
    sb.push_back(x);
  endtask

  task automatic idle();
    @(negedge clk);
    iact = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    n_vec++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d outputs still pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  // Reference arithmetic for the streaming vectors.
  function automatic longint rnd(input longint x);
    return (x + 64'sd16384) >>> 15;
  endfunction

  function automatic int fin(input longint x, input bit scale, inout bit clip);
    longint y;
    y = scale ? ((x + 1) >>> 1) : x;
    if (y > 32767) begin clip = 1'b1; y = 32767; end
    if (y < -32768) begin clip = 1'b1; y = -32768; end
    return int'(y);
  endfunction

  task automatic model(input longint ar, input longint ai, input longint br,
                       input longint bi, input longint wr, input longint wi,
                       input bit mode, input bit scale,
                       output int oar, output int oai, output int obr, output int obi);
    longint xr, xi, yr, yi, tr, ti;
    bit clip;
    clip = 1'b0;
    if (!mode) begin
      xr = ar + br;
      xi = ai + bi;
      yr = rnd((ar - br) * wr - (ai - bi) * wi);
      yi = rnd((ar - br) * wi + (ai - bi) * wr);
    end else begin
      tr = rnd(br * wr - bi * wi);
      ti = rnd(br * wi + bi * wr);
      xr = ar + tr;
      xi = ai + ti;
      yr = ar - tr;
      yi = ai - ti;
    end
    oar = fin(xr, scale, clip);
    oai = fin(xi, scale, clip);
    obr = fin(yr, scale, clip);
    obi = fin(yi, scale, clip);
  endtask

  int s_ar[8] = '{1000, -2000, 32767, -32768, 123, 4567, -30000, 20000};
  int s_ai[8] = '{200, 1500, -32768, 32767, -321, -4567, 30000, -20000};
  int s_br[8] = '{300, 2500, 32767, 32767, 7, -8000, -30000, 20000};
  int s_bi[8] = '{-100, -700, -32768, -1, -9, 8000, 25000, 15000};
  int s_wr[8] = '{-32768, 23170, 0, -32768, 32767, 0, 23170, -23170};
  int s_wi[8] = '{0, -23170, -32768, 0, 0, 32767, 23170, -23170};

  initial begin
    int k;
    int er, ei, fr, fi;
    reset = 1'b1; iact = 1'b0; ictrl = '0; iaddr = '0; imode = 1'b0; iscale = 1'b0;
    a_re = '0; a_im = '0; b_re = '0; b_im = '0; w_re = '0; w_im = '0; ovf_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_oact", {31'b0, oact}, 0);
    chk("reset_ovf", {31'b0, ovf}, 0);
    chk("reset_oa_re", $signed(oa_re), 0);
    chk("reset_octrl", {30'b0, octrl}, 0);
    chk("reset_oaddr", {23'b0, oaddr}, 0);
    reset = 1'b0;

    // DIF with W = -1.0
    drive(1, 'h15, 0, 0, 1000, 200, 300, -100, -32768, 0);
    push(1, 'h15, 1300, 100, -700, -300);
    idle();
    drain();
    chk("dif_ovf", {31'b0, ovf}, 0);

    // DIT with W = -j
    drive(2, 'h2a, 1, 0, 1000, 200, 300, -100, 0, -32768);
    push(2, 'h2a, 900, -100, 1100, 500);
    idle();
    drain();

    // Saturation, then scaled without saturation
    drive(3, 'h100, 0, 0, 32767, 0, 32767, 0, 32767, 0);
    push(3, 'h100, 32767, 0, 0, 0);
    idle();
    drain();
    chk("sat_ovf_set", {31'b0, ovf}, 1);
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk("ovf_cleared", {31'b0, ovf}, 0);
    drive(0, 'h101, 0, 1, 32767, 0, 32767, 0, 32767, 0);
    push(0, 'h101, 32767, 0, 0, 0);
    idle();
    drain();
    chk("scaled_ovf", {31'b0, ovf}, 0);

    // Back-to-back stream, mixed modes and scaling
    for (int i = 0; i < 8; i++) begin
      drive(i % 4, i, i[0], i[1], s_ar[i], s_ai[i], s_br[i], s_bi[i], s_wr[i], s_wi[i]);
      model(s_ar[i], s_ai[i], s_br[i], s_bi[i], s_wr[i], s_wi[i], i[0], i[1],
            er, ei, fr, fi);
      push(i % 4, i, er, ei, fr, fi);
    end
    idle();
    drain();

    // Set lands on the same edge as ovf_clr: set wins; clr alone then clears.
    @(negedge clk); ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    drive(1, 'h1f0, 1, 0, 32767, 0, 32767, 0, 32767, 0);
    push(1, 'h1f0, 32767, 0, 1, 0);
    k = cyc;
    idle();
    while (cyc < k + 4) @(negedge clk);
    chk("ovf_before_set", {31'b0, ovf}, 0);
    ovf_clr = 1'b1;
    @(negedge clk);
    chk("ovf_set_wins", {31'b0, ovf}, 1);
    @(negedge clk);
    chk("ovf_clr_alone", {31'b0, ovf}, 0);
    ovf_clr = 1'b0;
    drain();

    // Reset mid-flight: make outputs and ovf non-zero first
    drive(2, 'h0aa, 0, 0, 30000, -5000, 30000, 1000, 16384, 0);
    push(2, 'h0aa, 32767, -4000, 0, -3000);
    idle();
    drain();
    chk("pre_reset_ovf", {31'b0, ovf}, 1);
    drive(1, 1, 0, 0, 100, 200, 300, 400, 16384, 0);
    drive(2, 2, 1, 0, 500, 600, 700, 800, 0, 16384);
    drive(3, 3, 0, 1, 32767, 32767, -32768, -32768, 32767, 0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    iact  = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_oact", {31'b0, oact}, 0);
    chk("rst_ovf", {31'b0, ovf}, 0);
    chk("rst_oa_re", $signed(oa_re), 0);
    chk("rst_oa_im", $signed(oa_im), 0);
    chk("rst_ob_re", $signed(ob_re), 0);
    chk("rst_ob_im", $signed(ob_im), 0);
    chk("rst_oaddr", {23'b0, oaddr}, 0);
    chk("rst_octrl", {30'b0, octrl}, 0);
    drive(3, 'h1ff, 0, 0, 1000, 200, 300, -100, -32768, 0);
    push(3, 'h1ff, 1300, 100, -700, -300);
    idle();
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
